// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for the sequential divider.
interface seq_divider_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             divByZero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, divByZero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, divByZero
   );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per SHIFT/SUB pair.
// Define SEQ_DIVIDER_DIV0_FAST_EN to short-circuit a zero divisor straight from INIT to DONE.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rstN,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, INIT, SHIFT, SUB, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_by_zero_q, div_by_zero_d;
   logic [WIDTH:0]   trial;

   // R stays below 2*D, so a WIDTH+1 bit trial subtraction never overflows.
   assign trial = r_q - {1'b0, d_q};

   always_comb begin
      state_d       = state_q;
      r_d           = r_q;
      q_d           = q_q;
      d_d           = d_q;
      cnt_d         = cnt_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;
      case (state_q)
         IDLE: begin
            if (bus.start) state_d = INIT;
         end
         INIT: begin
            r_d   = '0;
            q_d   = bus.dividend;
            d_d   = bus.divisor;
            cnt_d = '0;
`ifdef SEQ_DIVIDER_DIV0_FAST_EN
            if (bus.divisor == '0) begin
               state_d       = DONE;
               quotient_d    = '1;
               remainder_d   = bus.dividend;
               div_by_zero_d = 1'b1;
            end else begin
               state_d = SHIFT;
            end
`else
            state_d = SHIFT;
`endif
         end
         SHIFT: begin
            {r_d, q_d} = {r_q[WIDTH-1:0], q_q, 1'b0};
            state_d    = SUB;
         end
         SUB: begin
            if (!trial[WIDTH]) begin
               r_d = trial;
               q_d = {q_q[WIDTH-1:1], 1'b1};
            end
            // Results are captured from this iteration's outcome on the edge into DONE.
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d       = DONE;
               quotient_d    = q_d;
               remainder_d   = r_d[WIDTH-1:0];
               div_by_zero_d = (d_q == '0);
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = SHIFT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q       <= IDLE;
         r_q           <= '0;
         q_q           <= '0;
         d_q           <= '0;
         cnt_q         <= '0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         r_q           <= r_d;
         q_q           <= q_d;
         d_q           <= d_d;
         cnt_q         <= cnt_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign bus.busy      = (state_q == INIT) || (state_q == SHIFT) || (state_q == SUB);
   assign bus.done      = (state_q == DONE);
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.divByZero = div_by_zero_q;
endmodule
